// File: rtl/decade_counter_nd.sv
// Multi-digit up/down decade counter with 8421 or 2421 (Aiken) digit output.
// Optional synchronous parallel load is built only when DECADE_LOAD_EN is defined.
module decade_counter_nd #(
    parameter int DIGITS = 2,
    parameter bit CODE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  x,
    input  logic                  up,
`ifdef DECADE_LOAD_EN
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
`endif
    output logic [4*DIGITS-1:0]   res,
    output logic                  z,
    output logic                  wrap
);

    logic [4*DIGITS-1:0] r_state;
    logic                r_wrap;
    logic [4*DIGITS-1:0] w_next;
    logic [4*DIGITS-1:0] w_load_val;
    logic                w_load;
    logic                w_carry;
    logic                w_all9;
    logic                w_all0;
    logic                w_term;

    function automatic logic [3:0] f_enc2421(input logic [3:0] d);
        logic [3:0] e;
        case (d)
            4'd5:    e = 4'b1011;
            4'd6:    e = 4'b1100;
            4'd7:    e = 4'b1101;
            4'd8:    e = 4'b1110;
            4'd9:    e = 4'b1111;
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: e = d;
            default: e = 4'b0000;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] f_clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

`ifdef DECADE_LOAD_EN
    assign w_load = load;

    // Out-of-range load digits are forced to zero so the state stays in 0..9.
    always_comb begin
        w_load_val = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_load_val[4*k +: 4] = f_clamp(din[4*k +: 4]);
        end
    end
`else
    assign w_load     = 1'b0;
    assign w_load_val = '0;
`endif

    // Ripple the carry/borrow from digit 0 upward to form the counted state.
    always_comb begin
        w_next  = r_state;
        w_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_carry) begin
                if (up) begin
                    if (r_state[4*k +: 4] == 4'd9) begin
                        w_next[4*k +: 4] = 4'd0;
                    end else begin
                        w_next[4*k +: 4] = r_state[4*k +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_state[4*k +: 4] == 4'd0) begin
                        w_next[4*k +: 4] = 4'd9;
                    end else begin
                        w_next[4*k +: 4] = r_state[4*k +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end else begin
                w_next[4*k +: 4] = r_state[4*k +: 4];
            end
        end
    end

    // Detect the all-nines and all-zeros terminal states.
    always_comb begin
        w_all9 = 1'b1;
        w_all0 = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_state[4*k +: 4] != 4'd9) begin
                w_all9 = 1'b0;
            end else begin
                w_all9 = w_all9;
            end
            if (r_state[4*k +: 4] != 4'd0) begin
                w_all0 = 1'b0;
            end else begin
                w_all0 = w_all0;
            end
        end
    end

    assign w_term = x & ~w_load & (up ? w_all9 : w_all0);
    assign z      = w_term;

    // Counter state: load has priority over counting, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= '0;
        end else if (w_load) begin
            r_state <= w_load_val;
        end else if (x) begin
            r_state <= w_next;
        end else begin
            r_state <= r_state;
        end
    end

    // Wrap pulse follows the terminal-count cycle by exactly one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_term;
        end
    end

    assign wrap = r_wrap;

    // Per-digit output encoding of the internal 8421 state.
    always_comb begin
        res = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (CODE) begin
                res[4*k +: 4] = f_enc2421(r_state[4*k +: 4]);
            end else begin
                res[4*k +: 4] = r_state[4*k +: 4];
            end
        end
    end

endmodule

// File: tb/tb_decade_counter_nd.sv
// Directed bench for decade_counter_nd: a 2421 instance and an 8421 instance share stimulus.
// Load checks are compiled in only with DECADE_LOAD_EN.
module tb_decade_counter_nd;

    logic       clk;
    logic       reset;
    logic       x;
    logic       up;
`ifdef DECADE_LOAD_EN
    logic       load;
    logic [7:0] din;
`endif
    logic [7:0] res_a;
    logic [7:0] res_b;
    logic       z_a;
    logic       z_b;
    logic       wrap_a;
    logic       wrap_b;

    int n_tests;
    int n_fail;

    decade_counter_nd #(.DIGITS(2), .CODE(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .up    (up),
`ifdef DECADE_LOAD_EN
        .load  (load),
        .din   (din),
`endif
        .res   (res_a),
        .z     (z_a),
        .wrap  (wrap_a)
    );

    decade_counter_nd #(.DIGITS(2), .CODE(1'b0)) u_dut_bcd (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .up    (up),
`ifdef DECADE_LOAD_EN
        .load  (load),
        .din   (din),
`endif
        .res   (res_b),
        .z     (z_b),
        .wrap  (wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        x       = 1'b0;
        up      = 1'b1;
`ifdef DECADE_LOAD_EN
        load    = 1'b0;
        din     = 8'h00;
`endif
        #1;
        chk8("rst_res", res_a, 8'h00);
        chk1("rst_wrap", wrap_a, 1'b0);

        // Reset held for 50 ns with x toggling and direction varying.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk8("rst_hold_res", res_a, 8'h00);
            chk1("rst_hold_wrap", wrap_a, 1'b0);
            x  = ~x;
            up = (i >= 2) ? 1'b0 : 1'b1;
            #1;
            chk1("rst_z", z_a, x & ~up);
        end

        @(negedge clk);
        reset = 1'b1;
        x     = 1'b1;
        up    = 1'b1;
        @(negedge clk);
        chk8("first_count", res_a, 8'h01);

        repeat (8) @(negedge clk);
        chk8("up_09_2421", res_a, 8'h0F);
        chk8("up_09_bcd", res_b, 8'h09);
        chk1("z_at_09", z_a, 1'b0);

        @(negedge clk);
        chk8("up_10_2421", res_a, 8'h10);
        chk8("up_10_bcd", res_b, 8'h10);

        repeat (89) @(negedge clk);
        chk8("up_99_2421", res_a, 8'hFF);
        chk8("up_99_bcd", res_b, 8'h99);
        chk1("z_at_99", z_a, 1'b1);
        chk1("wrap_before", wrap_a, 1'b0);

        @(negedge clk);
        chk8("upwrap_res", res_a, 8'h00);
        chk1("upwrap_pulse", wrap_a, 1'b1);
        chk1("z_after_upwrap", z_a, 1'b0);
        x = 1'b0;
        #1;
        chk1("z_x_low", z_a, 1'b0);

        @(negedge clk);
        chk1("upwrap_drop", wrap_a, 1'b0);
        chk8("hold_res", res_a, 8'h00);

        x  = 1'b1;
        up = 1'b0;
        #1;
        chk1("z_down_00", z_a, 1'b1);
        @(negedge clk);
        chk8("downwrap_2421", res_a, 8'hFF);
        chk8("downwrap_bcd", res_b, 8'h99);
        chk1("downwrap_pulse", wrap_a, 1'b1);
        chk1("downwrap_pulse_bcd", wrap_b, 1'b1);
        x = 1'b0;
        @(negedge clk);
        chk1("downwrap_drop", wrap_a, 1'b0);
        chk8("down_hold", res_a, 8'hFF);

        // Direction flips take effect on the very next edge.
        x  = 1'b1;
        up = 1'b1;
        @(negedge clk);
        chk8("dir_up_wrap", res_b, 8'h00);
        chk1("dir_up_wrap_pulse", wrap_a, 1'b1);
        up = 1'b0;
        @(negedge clk);
        chk8("dir_down_wrap", res_b, 8'h99);
        chk1("dir_down_wrap_pulse", wrap_a, 1'b1);

        repeat (53) @(negedge clk);
        chk8("down_46_bcd", res_b, 8'h46);
        chk8("down_46_2421", res_a, 8'h4C);
        chk1("down_46_wrap", wrap_a, 1'b0);

        #2;
        reset = 1'b0;
        #1;
        chk8("async_rst_res", res_a, 8'h00);
        chk8("async_rst_bcd", res_b, 8'h00);
        chk1("async_rst_wrap", wrap_a, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        x     = 1'b1;
        up    = 1'b0;
        @(posedge clk);
        #1;
        chk1("pend_wrap_set", wrap_a, 1'b1);
        reset = 1'b0;
        #1;
        chk1("pend_wrap_kill", wrap_a, 1'b0);
        chk8("pend_res_clear", res_a, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        x     = 1'b0;
        up    = 1'b1;

`ifdef DECADE_LOAD_EN
        load = 1'b1;
        din  = 8'h57;
        x    = 1'b1;
        #1;
        chk1("load_z", z_a, 1'b0);
        @(negedge clk);
        chk8("load_57_2421", res_a, 8'hBD);
        chk8("load_57_bcd", res_b, 8'h57);
        chk1("load_no_wrap", wrap_a, 1'b0);
        din = 8'hA3;
        @(negedge clk);
        chk8("load_A3_2421", res_a, 8'h03);
        chk8("load_A3_bcd", res_b, 8'h03);
        din = 8'h99;
        @(negedge clk);
        #1;
        chk1("load_at_99_z", z_a, 1'b0);
        @(negedge clk);
        chk8("load_99_hold", res_b, 8'h99);
        chk1("load_99_no_wrap", wrap_a, 1'b0);
        load = 1'b0;
        @(negedge clk);
        chk8("after_load_count", res_b, 8'h00);
        chk1("after_load_wrap", wrap_a, 1'b1);
        x = 1'b0;
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
